// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg: shared types, constants and baud-divider helper for the UART RX.
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clocks per oversample tick, truncated and never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// uart_baud_tick: free-running divide-by-DIV tick, held at zero while disabled.
// Rev 1.0
// ============================================================================
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (!en_i || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte: oversampling 8N1 UART receiver with majority-vote bit decision.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err_o port.
// Rev 1.0
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       busy_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       frame_err_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  OS_S0    = OS_W'(MID - 1);
  localparam logic [OS_W-1:0]  OS_S1    = OS_W'(MID);
  localparam logic [OS_W-1:0]  OS_S2    = OS_W'(MID + 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       state, state_nxt;
  logic                 sync1, rx_s;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt, os_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [1:0]           samp, samp_nxt;
  logic [7:0]           data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 maj;
  logic                 os_last;
  logic                 parity_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt, perr_nxt;
  assign parity_ok = ~par_bad;
`else
  assign parity_ok = 1'b1;
`endif

  // rx_i is asynchronous; nothing downstream looks at it directly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1 <= IDLE_LEVEL;
      rx_s  <= IDLE_LEVEL;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state != IDLE),
    .tick_o (tick)
  );

  assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign os_last = (os_cnt == OS_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    samp_nxt  = samp;
    data_nxt  = data_o;
    valid_nxt = 1'b0;
    ferr_nxt  = frame_err_o;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = parity_err_o;
`endif
    if (state == IDLE) begin
      os_nxt = '0;
      if (rx_s == 1'b0) state_nxt = START;
    end else if (tick) begin
      os_nxt = os_last ? '0 : os_cnt + OS_W'(1);
      if (os_cnt == OS_S0) samp_nxt[0] = rx_s;
      if (os_cnt == OS_S1) samp_nxt[1] = rx_s;
      case (state)
        START: begin
          if (os_cnt == OS_S2 && maj) begin
            state_nxt = IDLE;
          end else if (os_last) begin
            state_nxt = DATA;
            bit_nxt   = '0;
          end
        end
        DATA: begin
          if (os_cnt == OS_S2) shift_nxt = {maj, shift[DATA_BITS-1:1]};
          if (os_last) begin
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_idx + BIT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (os_cnt == OS_S2) begin
            par_bad_nxt = maj ^ (^shift);
            if (maj ^ (^shift)) perr_nxt = 1'b1;
          end
          if (os_last) state_nxt = STOP;
        end
`endif
        STOP: begin
          if (os_cnt == OS_S2) begin
            if (maj) begin
              // Leave at mid-stop-bit so a back-to-back start edge is caught.
              state_nxt = IDLE;
              if (parity_ok) begin
                data_nxt  = shift;
                valid_nxt = 1'b1;
                ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_nxt  = 1'b0;
`endif
              end
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = BREAK;
              os_nxt    = '0;
            end
          end
        end
        BREAK: begin
          // os counts consecutive high ticks here.
          if (!rx_s) os_nxt = '0;
          else if (os_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      os_cnt      <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      samp        <= '0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      os_cnt      <= os_nxt;
      bit_idx     <= bit_nxt;
      shift       <= shift_nxt;
      samp        <= samp_nxt;
      data_o      <= data_nxt;
      valid_o     <= valid_nxt;
      busy_o      <= (state_nxt != IDLE);
      frame_err_o <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      par_bad      <= par_bad_nxt;
      parity_err_o <= perr_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_byte: directed plus random frames against a frame-level model.
// Rev 1.0
// ============================================================================
module tb_uart_rx_byte;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Valid expected around mid-stop-bit plus synchroniser delay.
  localparam int LAT_BASE = (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid, busy, ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  logic       exp_perr = 1'b0;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  time        valid_t_q[$];
  int         got_rd   = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       valid_d  = 1'b0;
  logic       busy_after_valid = 1'bx;

  uart_rx_byte #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .rx_i         (rx),
    .data_o       (data),
    .valid_o      (valid),
    .busy_o       (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (perr),
`endif
    .frame_err_o  (ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    valid_d <= valid;
    if (valid_d) busy_after_valid <= busy;
    if (valid) begin
      got_q.push_back(data);
      valid_t_q.push_back($time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic level, input int n);
    rx = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold((^b) ^ par_flip, BIT_CLKS);
    if (par_flip) exp_perr = 1'b1;
`endif
    hold(stop_bit, BIT_CLKS);
    if (!stop_bit) begin
      exp_ferr = 1'b1;
    end else if (!par_flip) begin
      exp_q.push_back(b);
      exp_data = b;
      exp_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      exp_perr = 1'b0;
`endif
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, " valid count"}, got_q.size() - got_rd, exp_q.size());
    while (got_rd < got_q.size() && exp_q.size() > 0) begin
      check({tag, " byte"}, got_q[got_rd], exp_q.pop_front());
      got_rd++;
    end
    got_rd = got_q.size();
    exp_q.delete();
    check({tag, " data_o"}, data, exp_data);
    check({tag, " frame_err"}, ferr, exp_ferr);
`ifdef UART_RX_PARITY_EN
    check({tag, " parity_err"}, perr, exp_perr);
`endif
  endtask

  initial begin
    time t0;
    int  lat, gap, idx;
    logic [7:0] b;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset data_o", data, 8'h00);
    check("reset valid", valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset frame_err", ferr, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    // Single good frame, latency and busy release.
    t0 = $time;
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 20);
    lat = (valid_t_q.size() > got_rd) ? int'((valid_t_q[got_rd] - t0) / 10) : -1;
    check("A5 latency window", (lat >= LAT_BASE - 2 && lat <= LAT_BASE + 10), 1'b1);
    check("A5 busy after valid", busy_after_valid, 1'b0);
    check_rx("A5");

    // Back-to-back frames without idle.
    idx = got_rd;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, 20);
    gap = (valid_t_q.size() >= idx + 2) ? int'((valid_t_q[idx+1] - valid_t_q[idx]) / 10) : 0;
    check("b2b spacing", (gap >= FRAME_BITS * BIT_CLKS - 2 && gap <= FRAME_BITS * BIT_CLKS + 2), 1'b1);
    check_rx("b2b");

    // Short low glitch on an idle line.
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch busy", busy, 1'b0);
    check_rx("glitch");

    // Bad stop bit followed by a held-low line.
    send_frame(8'h12, 1'b0, 1'b0);
    hold(1'b0, 40);
    check("break held busy", busy, 1'b1);
    check_rx("bad stop");
    hold(1'b1, 40);
    check("break release busy", busy, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    hold(1'b1, 20);
    check_rx("after break");

    // Reset in the middle of bit 4.
    b = 8'h55;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(b[i], BIT_CLKS);
    hold(b[4], BIT_CLKS / 2);
    rst_n = 1'b0;
    #1;
    check("midreset data_o", data, 8'h00);
    check("midreset valid", valid, 1'b0);
    check("midreset busy", busy, 1'b0);
    check("midreset frame_err", ferr, 1'b0);
    exp_data = 8'h00;
    exp_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    exp_perr = 1'b0;
`endif
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 40);
    send_frame(8'h0F, 1'b1, 1'b0);
    hold(1'b1, 20);
    check_rx("after reset");

    // Random bytes with random idle gaps, including none.
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      hold(1'b1, int'($urandom_range(0, 24)));
    end
    hold(1'b1, 20);
    check_rx("random");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    check_rx("parity good");
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_rx("parity bad");
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, 20);
    check_rx("parity recover");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Oversampling UART receiver, 8N1 frame format.
- Recovers bytes from the serial line and holds the last good byte on data_o.
- data_o drives the 8-bit input of the seven-segment display driver directly downstream.
- Also provides a one-cycle valid strobe and sticky framing-error status for the rest of the design.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit; must be even and at least 8.
- Derived localparam DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated, minimum 1. Default DIV is 54.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  reset; asynchronous assert, active-low.
- rx_i  input  1  serial line, idles high; asynchronous to clk_i.
- data_o  output  8  last correctly framed byte, held until the next good byte.
- valid_o  output  1  one-cycle pulse when data_o updates.
- busy_o  output  1  high while a frame is being received (state other than IDLE).
- frame_err_o  output  1  sticky flag; set on bad stop bit, cleared by the next good byte.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Outputs: data_o=8'h00, valid_o=0, busy_o=0, frame_err_o=0.
  - Internal: FSM=IDLE, synchroniser flops=1, all counters=0.
- Synchroniser: rx_i passes through 2 flops, giving rx_s. All decisions use rx_s only.
- Tick generator:
  - Counter 0..DIV-1; tick is a one-clock pulse on wrap.
  - Runs freely in every state except IDLE, where it is held at 0.
- Sample counter os: 0..OVERSAMPLE-1, advances on tick.
- Bit decision: majority of three samples taken at os = M-1, M, M+1, where M=OVERSAMPLE/2. The decision is final at os=M+1.
- FSM states:
  - IDLE:
    - rx_s=0 → START; os=0, tick counter=0.
  - START:
    - At os=M+1: majority=1 → false start, return to IDLE; no flags change.
    - Otherwise, at os=OVERSAMPLE-1 tick → DATA with bit index=0.
  - DATA:
    - Each bit's majority is shifted in LSB-first.
    - After bit index 7 completes (os=OVERSAMPLE-1 tick) → STOP.
  - STOP, decision at os=M+1:
    - Majority=1: data_o<=shift register, valid_o pulses for 1 clk, frame_err_o<=0, → IDLE. Returning at mid-stop-bit allows back-to-back frames.
    - Majority=0: frame_err_o<=1, data_o unchanged, no valid_o, → BREAK.
  - BREAK:
    - Wait for rx_s=1 sustained for OVERSAMPLE ticks → IDLE. This prevents a held-low line from retriggering.
- Latency: valid_o rises on the clock after the tick at os=M+1 of the stop bit.
  - Total from the start-bit falling edge is about 9.5 bit times plus 2-3 clocks of synchroniser delay.
- Glitch rejection: a low pulse shorter than about M samples aborts in START.
- Reset mid-frame: immediate return to IDLE. Any partial byte is discarded, and data_o returns to 8'h00.
- busy_o is registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: an even-parity bit is inserted between bit 7 and the stop bit (extra state PARITY, same sampling rule).
  - Added output port parity_err_o (1 bit, reset 0, sticky). It is set when the received parity mismatches the XOR of the data bits.
  - On mismatch, data_o and valid_o are suppressed even if the stop bit is good. Both sticky flags clear on the next fully good frame.
- Undefined: 8N1 only; no parity_err_o port; the PARITY state is not built.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK};
  - localparams DATA_BITS=8 and IDLE_LEVEL=1'b1;
  - function calc_div(clk_freq, baud, os).
- Sub-module uart_baud_tick (parameter DIV; ports clk_i, rst_i, en_i, tick_o) holds the tick counter. It is reusable by a future transmitter.

Test Plan:
All cases use CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16, so DIV=1 and one bit is 16 clocks.
- Send 8'hA5 as 8N1 → single valid_o pulse; data_o=8'hA5; frame_err_o=0; busy_o low within 1 clk after valid_o.
- Send 8'h3C then 8'hFF back-to-back with no idle gap → two valid_o pulses about 160 clks apart; data_o ends at 8'hFF.
- Low glitch of 4 clks on idle line → stays in IDLE; no valid_o; data_o unchanged.
- Frame 8'h12 with stop bit driven 0, then line held low 40 clks, then idle, then send 8'h34:
  - frame_err_o=1 and data_o keeps its prior value after the bad frame;
  - no retrigger during the low period;
  - 8'h34 gives valid_o, data_o=8'h34, frame_err_o=0.
- rst_i pulsed low during bit 4 of 8'h55 → all outputs at reset values at once; the next clean 8'h0F is received correctly.
- With UART_RX_PARITY_EN defined:
  - 8'h07 with parity bit 1 → valid_o, data_o=8'h07;
  - 8'h07 with parity bit 0 → parity_err_o=1, no valid_o, data_o unchanged.
